key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 84 ++++++++
 tb/tb_key_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button front end: per-lane two-flop synchroniser, polarity normalisation,
// consecutive-sample debounce and registered one-cycle press/release pulses.
module key_conditioner #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic [WIDTH-1:0] KEY,
   output logic [WIDTH-1:0] KEY_STABLE,
   output logic [WIDTH-1:0] KEY_PRESS,
   output logic [WIDTH-1:0] KEY_RELEASE
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } lane_state_t;

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_press;
   logic [WIDTH-1:0] r_release;
   logic [CW-1:0]    r_cnt   [WIDTH];
   lane_state_t      r_state [WIDTH];
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_stable;

   // Logical sample: 1 means pressed regardless of board polarity.
   assign w_p = r_s2 ^ {WIDTH{ACTIVE_LOW}};

   // Synchroniser, debounce counter and lane state machine for every lane.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_s1      <= {WIDTH{ACTIVE_LOW}};
         r_s2      <= {WIDTH{ACTIVE_LOW}};
         r_press   <= {WIDTH{1'b0}};
         r_release <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i]   <= CNT_ZERO;
            r_state[i] <= RELEASED;
         end
      end else begin
         r_s1 <= KEY;
         r_s2 <= r_s1;
         for (int i = 0; i < WIDTH; i++) begin
            if (lane_state_t'(w_p[i]) == r_state[i]) begin
               // A sample matching the accepted level aborts any qualification.
               r_cnt[i]     <= CNT_ZERO;
               r_press[i]   <= 1'b0;
               r_release[i] <= 1'b0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_cnt[i]     <= CNT_ZERO;
               r_state[i]   <= lane_state_t'(w_p[i]);
               r_press[i]   <= w_p[i];
               r_release[i] <= ~w_p[i];
            end else begin
               r_cnt[i]     <= r_cnt[i] + CNT_ONE;
               r_press[i]   <= 1'b0;
               r_release[i] <= 1'b0;
            end
         end
      end
   end

   // Flatten the per-lane state into the level output.
   always_comb begin
      w_stable = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         w_stable[i] = (r_state[i] == PRESSED) ? 1'b1 : 1'b0;
      end
   end

   assign KEY_STABLE  = w_stable;
   assign KEY_PRESS   = r_press;
   assign KEY_RELEASE = r_release;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed vector table, hand-written corner sequences
// and randomized key activity against a sample-history reference model.
module tb_key_conditioner;

   localparam int DC = 4;

   typedef struct {
      bit         rst;
      logic [3:0] key;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic [3:0] key0, key1;
   logic [3:0] st0, pr0, rl0, st1, pr1, rl1;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   key_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) u_hi (
      .CLOCK_50(clk), .RESET(rst0), .KEY(key0),
      .KEY_STABLE(st0), .KEY_PRESS(pr0), .KEY_RELEASE(rl0));

   key_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) u_lo (
      .CLOCK_50(clk), .RESET(rst1), .KEY(key1),
      .KEY_STABLE(st1), .KEY_PRESS(pr1), .KEY_RELEASE(rl1));

   // Reference model: raw keys take two edges to become samples; a lane accepts
   // a new level once its last DC samples since the previous decision all differ.
   logic [3:0] m_s1 [2];
   logic [3:0] m_s2 [2];
   logic [3:0] m_st [2];
   logic [3:0] m_pr [2];
   logic [3:0] m_rl [2];
   logic [3:0] m_hist [2][$];
   int         m_mark [2][4];

   function automatic logic [3:0] idle_level(input int inst);
      return (inst == 1) ? 4'hF : 4'h0;
   endfunction

   task automatic model_edge(input int inst, input bit rst, input logic [3:0] key);
      logic [3:0] p;
      int         n;
      bit         all_differ;
      if (rst) begin
         m_s1[inst] = idle_level(inst);
         m_s2[inst] = idle_level(inst);
         m_st[inst] = 4'h0;
         m_pr[inst] = 4'h0;
         m_rl[inst] = 4'h0;
         for (int l = 0; l < 4; l++) m_mark[inst][l] = m_hist[inst].size();
      end else begin
         p = m_s2[inst] ^ idle_level(inst);
         m_hist[inst].push_back(p);
         n = m_hist[inst].size();
         m_pr[inst] = 4'h0;
         m_rl[inst] = 4'h0;
         for (int l = 0; l < 4; l++) begin
            all_differ = (n - m_mark[inst][l]) >= DC;
            if (all_differ) begin
               for (int k = n - DC; k < n; k++) begin
                  if (m_hist[inst][k][l] == m_st[inst][l]) all_differ = 1'b0;
               end
            end
            if (p[l] == m_st[inst][l]) begin
               m_mark[inst][l] = n;
            end else if (all_differ) begin
               m_st[inst][l] = p[l];
               m_pr[inst][l] = p[l];
               m_rl[inst][l] = ~p[l];
               m_mark[inst][l] = n;
            end
         end
         m_s2[inst] = m_s1[inst];
         m_s1[inst] = key;
      end
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One clock: drive away from the edge, advance the model, sample 1 time unit after.
   task automatic step(input bit r0, input logic [3:0] k0, input bit r1, input logic [3:0] k1);
      @(negedge clk);
      rst0 = r0; key0 = k0; rst1 = r1; key1 = k1;
      @(posedge clk);
      model_edge(0, r0, k0);
      model_edge(1, r1, k1);
      #1;
      chk("model_stable_hi", st0, m_st[0]);
      chk("model_press_hi", pr0, m_pr[0]);
      chk("model_release_hi", rl0, m_rl[0]);
      chk("model_stable_lo", st1, m_st[1]);
      chk("model_press_lo", pr1, m_pr[1]);
      chk("model_release_lo", rl1, m_rl[1]);
   endtask

   vec_t       tbl[$];
   logic [3:0] rk0, rk1;
   bit         rr;

   function automatic vec_t mk(input bit r, input logic [3:0] k, input logic [3:0] s,
                               input logic [3:0] p, input logic [3:0] l);
      vec_t v;
      v.rst = r; v.key = k; v.st = s; v.pr = p; v.rl = l;
      return v;
   endfunction

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; key0 = 4'h0; key1 = 4'hF;
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = idle_level(i); m_s2[i] = idle_level(i);
         m_st[i] = 4'h0; m_pr[i] = 4'h0; m_rl[i] = 4'h0;
         for (int l = 0; l < 4; l++) m_mark[i][l] = 0;
      end

      // Reset, idle, then a clean press and release on lane 0.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h1, 4'h1, 4'h1, 4'h0));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].key, tbl[i].rst, 4'hF);
         chk("tbl_stable", st0, tbl[i].st);
         chk("tbl_press", pr0, tbl[i].pr);
         chk("tbl_release", rl0, tbl[i].rl);
         chk("lo_idle_press", pr1, 4'h0);
      end

      for (int i = 0; i < 20; i++) begin
         step(1'b0, 4'h0, 1'b0, 4'hF);
         chk("idle_pulses", pr0 | rl0 | pr1 | rl1, 4'h0);
      end

      // Bounce on lane 2: only the final sustained run of 1s is accepted.
      for (int t = 0; t < 14; t++) begin
         logic [7:0] seq;
         seq = 8'b1110_1101;
         step(1'b0, (t < 8 && !seq[t]) ? 4'h0 : 4'h4, 1'b0, 4'hF);
         chk("bounce_press", pr0, (t == 10) ? 4'h4 : 4'h0);
      end
      for (int t = 0; t < 8; t++) step(1'b0, 4'h0, 1'b0, 4'hF);

      // Two lanes pressed on the same edge pulse together.
      for (int t = 0; t < 8; t++) begin
         step(1'b0, 4'hA, 1'b0, 4'hF);
         chk("simul_press", pr0, (t == 5) ? 4'hA : 4'h0);
      end
      for (int t = 0; t < 8; t++) step(1'b0, 4'h0, 1'b0, 4'hF);

      // Reset two edges into qualification; the press re-qualifies from deassertion.
      step(1'b0, 4'h1, 1'b0, 4'hF);
      step(1'b0, 4'h1, 1'b0, 4'hF);
      step(1'b1, 4'h1, 1'b0, 4'hF);
      chk("rst_mid_press", pr0, 4'h0);
      chk("rst_mid_stable", st0, 4'h0);
      for (int t = 0; t < 8; t++) begin
         step(1'b0, 4'h1, 1'b0, 4'hF);
         chk("rst_requal_press", pr0, (t == 5) ? 4'h1 : 4'h0);
      end
      for (int t = 0; t < 8; t++) step(1'b0, 4'h0, 1'b0, 4'hF);

      // Active-low instance: a raw 0 on lane 2 is a press.
      for (int t = 0; t < 8; t++) begin
         step(1'b0, 4'h0, 1'b0, 4'hB);
         chk("al_press", pr1, (t == 5) ? 4'h4 : 4'h0);
         chk("al_stable", st1, (t >= 5) ? 4'h4 : 4'h0);
      end
      for (int t = 0; t < 8; t++) begin
         step(1'b0, 4'h0, 1'b0, 4'hF);
         chk("al_release", rl1, (t == 5) ? 4'h4 : 4'h0);
      end

      // Randomized toggling with occasional resets, checked against the model.
      rk0 = 4'h0; rk1 = 4'hF;
      for (int c = 0; c < 1500; c++) begin
         for (int l = 0; l < 4; l++) begin
            if ($urandom_range(0, 4) == 0) rk0[l] = ~rk0[l];
            if ($urandom_range(0, 4) == 0) rk1[l] = ~rk1[l];
         end
         rr = ($urandom_range(0, 99) == 0);
         step(rr, rk0, ($urandom_range(0, 99) == 0), rk1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
